digit_memory_scan: RTL
======================

// Module: digit_memory_scan
// PURPOSE
//  Parametrised DEPTH x DATA_W register memory, written from switches by a debounced push button.
//  Contents are shown on DATA_W/4 seven-segment hex digits, with a one-hot LED marking the displayed address.
//  Adds three things over the fixed 8x8 version: raw-button conditioning, a sequenced clear-all,
//  and an auto-scan mode that steps through all addresses. Sits between board switches/buttons and the display pins.
// PARAMETERS
//  DATA_W     8         word width; multiple of 4, range 4..32
//  DEPTH      8         number of words; power of 2, range 2..64
//  ADDR_W     3         $clog2(DEPTH); derived, never overridden
//  SCAN_DIV   50000000  clocks per address step in scan mode; >= 2
//  DEB_CYCLES 500000    clocks a synchronised button level must stay stable before it is accepted; >= 1
// PORTS
//  clk            in   1               system clock
//  reset          in   1               asynchronous, active-low reset
//  write_btn      in   1               raw write push button, active-high, asynchronous
//  clear_btn      in   1               raw clear-all push button, active-high, asynchronous
//  mode_scan      in   1               slide switch: 0 = manual address, 1 = auto-scan; asynchronous
//  switch_address in   ADDR_W          write address; also the display address in manual mode
//  switch_value   in   DATA_W          write data
//  indicate_led   out  DEPTH           one-hot of the displayed address
//  digit_segs     out  7*(DATA_W/4)    digit i = bits [7i+6:7i], showing nibble i of the displayed word
//  disp_addr      out  ADDR_W          currently displayed address
//  busy           out  1               high while clear-all is in progress
// BEHAVIOUR
//  Reset (reset=0), applied asynchronously:
//   - all words = 0; indicating = 0; disp_addr = 0; indicate_led = 1 (bit 0)
//   - busy = 0; FSM = IDLE; scan prescaler and pointer = 0; debouncers = 0
//   - digit_segs then show the '0' pattern on every digit.
//   - Reset during CLEAR aborts it; the memory is zero anyway.
//  Button conditioning (write_btn, clear_btn):
//   - 2-FF synchroniser, then a stability counter.
//   - The debounced level changes after DEB_CYCLES consecutive equal samples.
//   - A 1-clk pulse is produced on each debounced 0->1 edge. Holding the button gives exactly one pulse.
//  mode_scan: 2-FF synchronised, no debounce.
//  FSM states:
//   - IDLE:
//     - clear pulse -> CLEAR, busy=1, clr_ptr=0.
//     - Otherwise a write pulse sets mem[switch_address] = switch_value at that edge.
//     - Clear and write pulses in the same cycle: clear wins, the write is dropped.
//   - CLEAR: writes mem[clr_ptr]=0 and increments clr_ptr, one word per clk.
//     - On clr_ptr==DEPTH-1 -> IDLE at that edge, so busy is high for exactly DEPTH cycles.
//     - Write and clear pulses arriving in CLEAR are ignored, not queued.
//  Display address:
//   - Manual: disp_addr = switch_address, registered (1-clk latency).
//   - Scan: the prescaler counts 0..SCAN_DIV-1. At terminal count disp_addr increments, wrapping DEPTH-1 -> 0.
//   - On a synchronised 0->1 of mode_scan: prescaler=0 and disp_addr=switch_address.
//     Scan therefore starts from the manual address.
//   - Leaving scan mode: the manual address takes over on the next clk.
//  Read path:
//   - indicating <= mem[disp_addr] every clk (registered read). No read-during-write bypass.
//   - A write committed at edge k appears in indicating at edge k+1.
//  indicate_led: registered one-hot decode of disp_addr, updated the same edge as disp_addr.
//  digit_segs: combinational hex-to-7-seg decode of indicating, active-high segments.
//  The display keeps updating during CLEAR and shows zeros as words are cleared.
// STRUCTURE
//  Shared include digitmem_defs.vh holds:
//   - FSM state encodings ST_IDLE / ST_CLEAR (1 bit)
//   - a clog2 function
//   - the DATA_W%4 and DEPTH power-of-2 legality checks
//  Sub-module button_pulse (params DEB_CYCLES): synchroniser + debounce + rising-edge pulse.
//   - Instantiated twice, once for write_btn and once for clear_btn.
//  Existing hex2seven_seg is instantiated DATA_W/4 times in a generate loop.
//  Memory: generate loop of DEPTH registers with async clear.
// TESTING (DATA_W=8, DEPTH=8, DEB_CYCLES=4, SCAN_DIV=5)
//  1. Reset: drop reset mid-clock -> immediately disp_addr=0, indicate_led=8'h01, digits show '0', busy=0.
//  2. Write: addr=3, value=8'hA5, write_btn held 20 clks -> exactly one write.
//     Manual addr=3 then shows digit1='A', digit0='5', indicate_led=8'h08.
//  3. Bounce: write_btn toggles every 2 clks for 12 clks with value=8'h11 -> no write; mem[3] stays 8'hA5.
//  4. Clear: fill all 8 words, pulse clear_btn -> busy high exactly 8 clks, then all words 0.
//     A write pulse during busy is ignored.
//  5. Scan: switch_address=6, mode_scan 0->1 -> disp_addr goes 6,7,0,1 with 5 clks per step.
//     indicate_led tracks it one-hot.
//  6. Collision/abort: clear and write pulses in the same cycle -> clear only.
//     Reset asserted at clr_ptr=3 -> all zero, busy=0, FSM=IDLE.

Source files
------------

// File: rtl/digit_memory_scan_pkg.sv
// Shared definitions for the digit memory: FSM state encoding and a constant log2 helper.
package digit_memory_scan_pkg;

  localparam int SEG_W = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/digit_memory_scan_button_pulse.sv
// Raw push-button conditioning: 2-FF synchroniser, stability-count debounce and a
// one-clock pulse on each accepted 0->1 transition of the debounced level.
module button_pulse
  import digit_memory_scan_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_meta;
  logic             sync_lvl;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Two-stage synchroniser for the asynchronous button input.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_lvl  <= sync_meta;
    end
  end

  // Accept a new level after DEB_CYCLES consecutive samples that differ from the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync_lvl == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_lvl;
        cnt   <= '0;
        pulse <= sync_lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_memory_scan_hex2seven_seg.sv
// Hex nibble to active-high seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex2seven_seg (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Pure decode table.
  // NOTE: the output gets a default before the case so no latch can be inferred.
  always_comb begin
    segs = 7'h00;
    case (nibble)
      4'h0: segs = 7'h3F;
      4'h1: segs = 7'h06;
      4'h2: segs = 7'h5B;
      4'h3: segs = 7'h4F;
      4'h4: segs = 7'h66;
      4'h5: segs = 7'h6D;
      4'h6: segs = 7'h7D;
      4'h7: segs = 7'h07;
      4'h8: segs = 7'h7F;
      4'h9: segs = 7'h6F;
      4'hA: segs = 7'h77;
      4'hB: segs = 7'h7C;
      4'hC: segs = 7'h39;
      4'hD: segs = 7'h5E;
      4'hE: segs = 7'h79;
      4'hF: segs = 7'h71;
      default: segs = 7'h00;
    endcase
  end

endmodule

// File: rtl/digit_memory_scan.sv
// DEPTH x DATA_W register memory written from switches by a debounced button, with
// sequenced clear-all, manual/auto-scan display address and hex seven-segment readout.
module digit_memory_scan
  import digit_memory_scan_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = clog2(DEPTH),
  parameter int SCAN_DIV   = 50000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        write_btn,
  input  logic                        clear_btn,
  input  logic                        mode_scan,
  input  logic [ADDR_W-1:0]           switch_address,
  input  logic [DATA_W-1:0]           switch_value,
  output logic [DEPTH-1:0]            indicate_led,
  output logic [SEG_W*(DATA_W/4)-1:0] digit_segs,
  output logic [ADDR_W-1:0]           disp_addr,
  output logic                        busy
);

  localparam int PRE_W = clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  if ((DATA_W % 4) != 0 || DATA_W < 4 || DATA_W > 32) begin : g_bad_data_w
    $error("DATA_W must be a multiple of 4 in 4..32");
  end
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 || DEPTH > 64 || ADDR_W != clog2(DEPTH)) begin : g_bad_depth
    $error("DEPTH must be a power of 2 in 2..64 and ADDR_W must equal clog2(DEPTH)");
  end

  logic                  wr_pulse, clr_pulse;
  logic                  scan_meta, scan_sync, scan_prev, scan_rise;
  logic [PRE_W-1:0]      presc, presc_next;
  logic [ADDR_W-1:0]     disp_next;
  state_t                state, state_next;
  logic [ADDR_W-1:0]     clr_ptr, ptr_next;
  logic                  wr_en, clr_en;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     indicating;

  button_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_write_btn (
    .clk(clk), .rst_n(reset), .btn(write_btn), .pulse(wr_pulse)
  );
  button_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_clear_btn (
    .clk(clk), .rst_n(reset), .btn(clear_btn), .pulse(clr_pulse)
  );

  // Synchronise the scan switch and keep its previous value for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_meta <= 1'b0;
      scan_sync <= 1'b0;
      scan_prev <= 1'b0;
    end else begin
      scan_meta <= mode_scan;
      scan_sync <= scan_meta;
      scan_prev <= scan_sync;
    end
  end

  assign scan_rise = scan_sync & ~scan_prev;

  // Next display address: restart from the manual address on scan entry, step at terminal count.
  always_comb begin
    presc_next = presc;
    disp_next  = disp_addr;
    if (scan_rise) begin
      presc_next = '0;
      disp_next  = switch_address;
    end else if (scan_sync) begin
      if (presc == PRE_LAST) begin
        presc_next = '0;
        disp_next  = disp_addr + 1'b1;
      end else begin
        presc_next = presc + 1'b1;
      end
    end else begin
      disp_next = switch_address;
    end
  end

  // Display address, prescaler and one-hot LED all update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc        <= '0;
      disp_addr    <= '0;
      indicate_led <= DEPTH'(1);
    end else begin
      presc        <= presc_next;
      disp_addr    <= disp_next;
      indicate_led <= DEPTH'(1) << disp_next;
    end
  end

  // FSM state and clear pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= ptr_next;
    end
  end

  // FSM next state and memory strobes; a clear pulse beats a simultaneous write pulse.
  always_comb begin
    state_next = state;
    ptr_next   = clr_ptr;
    wr_en      = 1'b0;
    clr_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clr_pulse) begin
          state_next = ST_CLEAR;
          ptr_next   = '0;
        end else begin
          wr_en = wr_pulse;
        end
      end
      ST_CLEAR: begin
        clr_en   = 1'b1;
        ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == PTR_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CLEAR);

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    logic [DATA_W-1:0] word;

    // One memory word: cleared by the sequencer or written from the switches.
    // NOTE: words carry an async reset because a zeroed memory after reset is visible behaviour; true RAMs cannot do this.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        word <= '0;
      end else if (clr_en && clr_ptr == ADDR_W'(i)) begin
        word <= '0;
      end else if (wr_en && switch_address == ADDR_W'(i)) begin
        word <= switch_value;
      end
    end

    assign mem[i] = word;
  end

  // Registered read of the displayed word; no bypass of a same-edge write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      indicating <= '0;
    end else begin
      indicating <= mem[disp_addr];
    end
  end

  for (genvar d = 0; d < DATA_W / 4; d++) begin : g_digit
    hex2seven_seg u_seg (
      .nibble(indicating[4*d +: 4]),
      .segs  (digit_segs[SEG_W*d +: SEG_W])
    );
  end

endmodule
